// File: rtl/dup_ctrl_pkg.sv
// Shared types and constants for the duplex reconfiguration controller.
package dup_ctrl_pkg;

   localparam int MODE_W = 3;
   // Wide enough for PERSIST and MAX_RETRY up to 7.
   localparam int CNT_W  = 3;

   // Operating mode, also driven directly onto the mode output.
   typedef enum logic [MODE_W-1:0] {
      MODE_DUPLEX    = 3'd0,
      MODE_RETRY     = 3'd1,
      MODE_SIMPLEX_X = 3'd2,
      MODE_SIMPLEX_Y = 3'd3,
      MODE_FAIL      = 3'd4
   } mode_e;

   // Valid two-rail codes; 00 and 11 signal a self-detected error.
   localparam logic [1:0] TR_OK_A = 2'b01;
   localparam logic [1:0] TR_OK_B = 2'b10;

   // True when a copy's two-rail checker flags its own result as bad.
   function automatic logic two_rail_err(input logic [1:0] e);
      return !((e == TR_OK_A) || (e == TR_OK_B));
   endfunction

endpackage

// File: rtl/strike_counter.sv
// Saturating event counter. hit is high when the next increment reaches MAX,
// so the controller can act on the triggering event in the same decision.
module strike_counter
   import dup_ctrl_pkg::*;
#(
   parameter int MAX = 3
) (
   input  logic clk,
   input  logic rst_n,
   input  logic inc,
   input  logic clr,
   output logic hit
);

   localparam logic [CNT_W-1:0] LIMIT = CNT_W'(MAX);
   localparam logic [CNT_W-1:0] LAST  = CNT_W'(MAX - 1);

   logic [CNT_W-1:0] count;

   // Count events, clear on request, hold at LIMIT instead of wrapping.
   // NOTE: sequential state is written only with non-blocking assignments so
   // every register samples the pre-edge values of its neighbours.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (inc && (count < LIMIT)) begin
         count <= count + 1'b1;
      end
   end

   assign hit = (count >= LAST);

endmodule

// File: rtl/duplex_reconfig_ctrl.sv
// Voter / reconfiguration controller for a duplicated computation pair.
// Masks single-copy faults, requests recomputation on undiagnosable
// disagreement, degrades to simplex on persistent faults, latches FAIL.
module duplex_reconfig_ctrl
   import dup_ctrl_pkg::*;
#(
   parameter int DATA_W    = 4,
   parameter int PERSIST   = 3,
   parameter int MAX_RETRY = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] x_data,
   input  logic [1:0]        x_e,
   input  logic [DATA_W-1:0] y_data,
   input  logic [1:0]        y_e,
   input  logic              clear,
   output logic              out_valid,
   output logic [DATA_W-1:0] out_data,
   output logic              retry_req,
   output logic [MODE_W-1:0] mode,
   output logic              x_faulty,
   output logic              y_faulty,
   output logic              fail
);

   mode_e             state_q, state_d;
   logic              out_valid_d, retry_req_d;
   logic [DATA_W-1:0] out_data_d;
   logic              x_faulty_d, y_faulty_d, fail_d;

   logic xs_inc, xs_clr, xs_hit;
   logic ys_inc, ys_clr, ys_hit;
   logic rc_inc, rc_clr, rc_hit;

   logic xe, ye, mism;

   assign xe   = two_rail_err(x_e);
   assign ye   = two_rail_err(y_e);
   assign mism = (x_data != y_data);

   strike_counter #(.MAX(PERSIST)) u_xstrike (
      .clk(clk), .rst_n(rst_n), .inc(xs_inc), .clr(xs_clr), .hit(xs_hit)
   );

   strike_counter #(.MAX(PERSIST)) u_ystrike (
      .clk(clk), .rst_n(rst_n), .inc(ys_inc), .clr(ys_clr), .hit(ys_hit)
   );

   strike_counter #(.MAX(MAX_RETRY)) u_retry (
      .clk(clk), .rst_n(rst_n), .inc(rc_inc), .clr(rc_clr), .hit(rc_hit)
   );

   // Decide next mode, output values, flags and counter actions.
   // NOTE: every signal gets a default before any branch, so no path can
   // leave one unassigned and infer a latch.
   always_comb begin
      state_d     = state_q;
      out_valid_d = 1'b0;
      retry_req_d = 1'b0;
      out_data_d  = out_data;
      x_faulty_d  = x_faulty;
      y_faulty_d  = y_faulty;
      fail_d      = fail;
      xs_inc      = 1'b0;
      xs_clr      = 1'b0;
      ys_inc      = 1'b0;
      ys_clr      = 1'b0;
      rc_inc      = 1'b0;
      rc_clr      = 1'b0;

      if (clear) begin
         // Clear wins over a same-cycle result.
         state_d    = MODE_DUPLEX;
         x_faulty_d = 1'b0;
         y_faulty_d = 1'b0;
         fail_d     = 1'b0;
         xs_clr     = 1'b1;
         ys_clr     = 1'b1;
         rc_clr     = 1'b1;
      end else if (in_valid) begin
         unique case (state_q)
            MODE_DUPLEX, MODE_RETRY: begin
               if (!xe && !ye && !mism) begin
                  out_valid_d = 1'b1;
                  out_data_d  = x_data;
                  xs_clr      = 1'b1;
                  ys_clr      = 1'b1;
                  rc_clr      = 1'b1;
                  state_d     = MODE_DUPLEX;
               end else if (xe && !ye) begin
                  // X flagged itself: trust Y, count a strike against X.
                  out_valid_d = 1'b1;
                  out_data_d  = y_data;
                  xs_inc      = 1'b1;
                  if (xs_hit) begin
                     x_faulty_d = 1'b1;
                     state_d    = MODE_SIMPLEX_Y;
                  end else begin
                     state_d    = MODE_DUPLEX;
                  end
               end else if (ye && !xe) begin
                  out_valid_d = 1'b1;
                  out_data_d  = x_data;
                  ys_inc      = 1'b1;
                  if (ys_hit) begin
                     y_faulty_d = 1'b1;
                     state_d    = MODE_SIMPLEX_X;
                  end else begin
                     state_d    = MODE_DUPLEX;
                  end
               end else begin
                  // Both bad, or both clean but disagreeing: cannot tell
                  // which copy is right, so recompute or give up.
                  rc_inc = 1'b1;
                  if (rc_hit) begin
                     fail_d  = 1'b1;
                     state_d = MODE_FAIL;
                  end else begin
                     retry_req_d = 1'b1;
                     state_d     = MODE_RETRY;
                  end
               end
            end
            MODE_SIMPLEX_X: begin
               if (!xe) begin
                  out_valid_d = 1'b1;
                  out_data_d  = x_data;
               end else begin
                  fail_d  = 1'b1;
                  state_d = MODE_FAIL;
               end
            end
            MODE_SIMPLEX_Y: begin
               if (!ye) begin
                  out_valid_d = 1'b1;
                  out_data_d  = y_data;
               end else begin
                  fail_d  = 1'b1;
                  state_d = MODE_FAIL;
               end
            end
            default: begin
               // FAIL holds until clear or reset.
               state_d = MODE_FAIL;
            end
         endcase
      end
   end

   // Register mode and all outputs; reset discards any pending retry.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= MODE_DUPLEX;
         out_valid <= 1'b0;
         out_data  <= '0;
         retry_req <= 1'b0;
         x_faulty  <= 1'b0;
         y_faulty  <= 1'b0;
         fail      <= 1'b0;
      end else begin
         state_q   <= state_d;
         out_valid <= out_valid_d;
         out_data  <= out_data_d;
         retry_req <= retry_req_d;
         x_faulty  <= x_faulty_d;
         y_faulty  <= y_faulty_d;
         fail      <= fail_d;
      end
   end

   assign mode = state_q;

endmodule

// File: tb/tb_duplex_reconfig_ctrl.sv
// Self-checking bench for duplex_reconfig_ctrl: directed scenarios followed by
// randomized results, all compared against a behavioural model of the rules.
module tb_duplex_reconfig_ctrl;

   localparam int DATA_W    = 4;
   localparam int PERSIST   = 3;
   localparam int MAX_RETRY = 2;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              in_valid = 1'b0;
   logic [DATA_W-1:0] x_data = '0;
   logic [1:0]        x_e = 2'b01;
   logic [DATA_W-1:0] y_data = '0;
   logic [1:0]        y_e = 2'b01;
   logic              clear = 1'b0;
   logic              out_valid;
   logic [DATA_W-1:0] out_data;
   logic              retry_req;
   logic [2:0]        mode;
   logic              x_faulty, y_faulty, fail;

   int checks = 0;
   int errors = 0;

   // Behavioural model state (plain integers).
   int m_mode, m_xs, m_ys, m_rc;
   int m_valid, m_data, m_retry, m_xf, m_yf, m_fail;

   duplex_reconfig_ctrl #(
      .DATA_W(DATA_W), .PERSIST(PERSIST), .MAX_RETRY(MAX_RETRY)
   ) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
      .x_data(x_data), .x_e(x_e), .y_data(y_data), .y_e(y_e),
      .clear(clear), .out_valid(out_valid), .out_data(out_data),
      .retry_req(retry_req), .mode(mode), .x_faulty(x_faulty),
      .y_faulty(y_faulty), .fail(fail)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string ctx);
      check({ctx, " out_valid"}, int'(out_valid), m_valid);
      check({ctx, " out_data"},  int'(out_data),  m_data);
      check({ctx, " retry_req"}, int'(retry_req), m_retry);
      check({ctx, " mode"},      int'(mode),      m_mode);
      check({ctx, " x_faulty"},  int'(x_faulty),  m_xf);
      check({ctx, " y_faulty"},  int'(y_faulty),  m_yf);
      check({ctx, " fail"},      int'(fail),      m_fail);
   endtask

   task automatic model_reset();
      m_mode = 0; m_xs = 0; m_ys = 0; m_rc = 0;
      m_valid = 0; m_data = 0; m_retry = 0;
      m_xf = 0; m_yf = 0; m_fail = 0;
   endtask

   // Apply the voting rules to one cycle's inputs.
   task automatic model_step(input bit iv, input int xd, input int xe_code,
                             input int yd, input int ye_code, input bit clr);
      bit xerr, yerr, mism;
      xerr = (xe_code == 0) || (xe_code == 3);
      yerr = (ye_code == 0) || (ye_code == 3);
      mism = (xd != yd);
      m_valid = 0;
      m_retry = 0;
      if (clr) begin
         m_mode = 0; m_xs = 0; m_ys = 0; m_rc = 0;
         m_xf = 0; m_yf = 0; m_fail = 0;
      end else if (iv) begin
         if (m_mode == 0 || m_mode == 1) begin
            if (!xerr && !yerr && !mism) begin
               m_valid = 1; m_data = xd;
               m_xs = 0; m_ys = 0; m_rc = 0; m_mode = 0;
            end else if (xerr && !yerr) begin
               m_valid = 1; m_data = yd;
               m_xs = m_xs + 1;
               if (m_xs >= PERSIST) begin m_xf = 1; m_mode = 3; end
               else m_mode = 0;
            end else if (yerr && !xerr) begin
               m_valid = 1; m_data = xd;
               m_ys = m_ys + 1;
               if (m_ys >= PERSIST) begin m_yf = 1; m_mode = 2; end
               else m_mode = 0;
            end else begin
               m_rc = m_rc + 1;
               if (m_rc >= MAX_RETRY) begin m_mode = 4; m_fail = 1; end
               else begin m_retry = 1; m_mode = 1; end
            end
         end else if (m_mode == 2) begin
            if (!xerr) begin m_valid = 1; m_data = xd; end
            else begin m_mode = 4; m_fail = 1; end
         end else if (m_mode == 3) begin
            if (!yerr) begin m_valid = 1; m_data = yd; end
            else begin m_mode = 4; m_fail = 1; end
         end
      end
   endtask

   // Drive one cycle of inputs, advance model, check outputs after the edge.
   task automatic step(input string ctx, input bit iv, input int xd, input int xe_code,
                       input int yd, input int ye_code, input bit clr);
      in_valid = iv;
      x_data   = DATA_W'(xd);
      x_e      = 2'(xe_code);
      y_data   = DATA_W'(yd);
      y_e      = 2'(ye_code);
      clear    = clr;
      model_step(iv, xd, xe_code, yd, ye_code, clr);
      @(posedge clk);
      #1;
      check_all(ctx);
   endtask

   function automatic int rand_err_code();
      // Mostly valid codes, occasionally a self-flagged error.
      if ($urandom_range(99) < 80) return ($urandom_range(1) == 0) ? 1 : 2;
      return ($urandom_range(1) == 0) ? 0 : 3;
   endfunction

   initial begin
      model_reset();
      #12;
      check_all("reset");
      @(negedge clk);
      rst_n = 1'b1;

      // Clean agreement.
      step("clean", 1, 'hA, 1, 'hA, 1, 0);
      step("idle", 0, 0, 1, 0, 1, 0);

      // X self-flags three times: masked twice, then simplex on Y.
      step("mask1", 1, 3, 3, 5, 1, 0);
      step("mask2", 1, 3, 3, 5, 1, 0);
      step("mask3", 1, 3, 3, 5, 1, 0);
      step("simplex_y", 1, 7, 1, 9, 2, 0);
      // Y errs while alone -> FAIL, then clear.
      step("simplex_fail", 1, 2, 1, 4, 0, 0);
      step("fail_hold", 1, 6, 1, 6, 1, 0);
      step("clear", 1, 6, 1, 6, 1, 1);

      // Transient X errors broken by a clean result stay in DUPLEX.
      step("trans1", 1, 1, 0, 8, 2, 0);
      step("trans2", 1, 1, 0, 8, 2, 0);
      step("trans_clean", 1, 4, 2, 4, 1, 0);
      step("trans3", 1, 1, 3, 8, 1, 0);
      step("trans4", 1, 1, 3, 8, 1, 0);

      // Mismatch twice: retry, then FAIL.
      step("mism1", 1, 1, 1, 2, 1, 0);
      step("mism2", 1, 1, 1, 2, 1, 0);
      step("clear2", 0, 0, 1, 0, 1, 1);

      // Reset asserted while a retry is pending.
      step("mism_pre_reset", 1, 1, 1, 2, 1, 0);
      #2;
      rst_n = 1'b0;
      model_reset();
      #1;
      check_all("async_reset");
      @(negedge clk);
      rst_n = 1'b1;
      step("post_reset", 0, 0, 1, 0, 1, 0);

      // Randomized results against the model.
      for (int i = 0; i < 400; i++) begin
         int xd, yd, xc, yc;
         bit iv, clr;
         iv  = ($urandom_range(99) < 85);
         clr = ($urandom_range(99) < ((m_mode == 4) ? 30 : 3));
         xd  = $urandom_range(15);
         yd  = ($urandom_range(99) < 75) ? xd : $urandom_range(15);
         xc  = rand_err_code();
         yc  = rand_err_code();
         step("random", iv, xd, xc, yd, yc, clr);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
